// File: rtl/data_ram_ctrl.sv
// Single-port word-addressed data RAM on the CPU data bus with valid/ready
// request and response handshakes, byte-lane writes and programmable read latency.
module data_ram_ctrl #(
    parameter int                DATA_W     = 32,
    parameter int                DEPTH      = 100,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
    parameter int                RD_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Window end is one bit wider than the address so BASE_ADDR+DEPTH cannot wrap.
    localparam logic [ADDR_W:0] END_ADDR  = {1'b0, BASE_ADDR} + (ADDR_W + 1)'(DEPTH);
    localparam logic [2:0]      WAIT_INIT = 3'(RD_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [2:0]         cnt;
    logic [2:0]         cnt_next;
    logic [DATA_W-1:0]  mem [DEPTH];
    logic [DATA_W-1:0]  rdata_q;
    logic               err_q;
    logic               accept;
    logic               hit;
    logic [IDX_W-1:0]   idx;

    assign hit    = ({1'b0, req_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, req_addr} < END_ADDR);
    assign idx    = IDX_W'(req_addr - BASE_ADDR);
    assign accept = req_valid && req_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    if (RD_LATENCY <= 1) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt <= 3'd1) begin
                    state_next = RESP;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt - 3'd1;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Response payload is captured at acceptance and held until the handshake.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (accept) begin
            err_q   <= !hit;
            rdata_q <= (hit && !req_we) ? mem[idx] : '0;
        end else if (rsp_valid && rsp_ready) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end
    end

    // Array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (accept && req_we && hit) begin
            for (int i = 0; i < NB; i++) begin
                if (req_be[i]) begin
                    mem[idx][i*8 +: 8] <= req_wdata[i*8 +: 8];
                end
            end
        end
    end

    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;

endmodule
